// File: rtl/sys_result_buffer_if.sv
// Result-buffer bus between the controller/array side and sys_result_buffer.
// RESULT_ACCUM_EN adds the sticky accum_sat flag.
interface sys_result_buffer_if #(
    parameter int DATA_W = 16
);
    logic              clr;
    logic              we_c11;
    logic              we_c12;
    logic              we_c21;
    logic              we_c22;
    logic [DATA_W-1:0] din_c11;
    logic [DATA_W-1:0] din_c12;
    logic [DATA_W-1:0] din_c21;
    logic [DATA_W-1:0] din_c22;
    logic              rd_en;
    logic [1:0]        rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_hit;
    logic [3:0]        entry_valid;
    logic              full;
    logic              scan_start;
    logic              scan_busy;
    logic [1:0]        scan_addr;
    logic [DATA_W-1:0] scan_data;
    logic              scan_done;
`ifdef RESULT_ACCUM_EN
    logic              accum_sat;
`endif

    modport master (
        output clr,
        output we_c11, we_c12, we_c21, we_c22,
        output din_c11, din_c12, din_c21, din_c22,
        output rd_en, rd_addr, scan_start,
        input  rd_data, rd_valid, rd_hit,
        input  entry_valid, full,
        input  scan_busy, scan_addr, scan_data, scan_done
`ifdef RESULT_ACCUM_EN
        , input accum_sat
`endif
    );

    modport slave (
        input  clr,
        input  we_c11, we_c12, we_c21, we_c22,
        input  din_c11, din_c12, din_c21, din_c22,
        input  rd_en, rd_addr, scan_start,
        output rd_data, rd_valid, rd_hit,
        output entry_valid, full,
        output scan_busy, scan_addr, scan_data, scan_done
`ifdef RESULT_ACCUM_EN
        , output accum_sat
`endif
    );
endinterface

// File: rtl/sys_result_buffer.sv
// 2x2 result tile buffer: capture, registered random read, timed scan-out.
// Define RESULT_ACCUM_EN for saturating accumulate-on-rewrite.
module sys_result_buffer #(
    parameter int DATA_W      = 16,
    parameter int HOLD_CYCLES = 4
) (
    input logic                 clk,
    input logic                 rstb,
    sys_result_buffer_if.slave  bus
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SHOW,
        S_DONE
    } state_e;

    logic [3:0]        we;
    logic [DATA_W-1:0] din [4];

    logic [DATA_W-1:0] mem_q [4];
    logic [DATA_W-1:0] mem_d [4];
    logic [3:0]        vld_q;
    logic [3:0]        vld_d;

    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              rd_hit_q;

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [1:0]        saddr_q;
    logic [1:0]        saddr_d;
    logic [DATA_W-1:0] sdata_q;
    logic [DATA_W-1:0] sdata_d;

    logic              full;

    assign we     = {bus.we_c22, bus.we_c21, bus.we_c12, bus.we_c11};
    assign din[0] = bus.din_c11;
    assign din[1] = bus.din_c12;
    assign din[2] = bus.din_c21;
    assign din[3] = bus.din_c22;

    assign full = &vld_q;

`ifdef RESULT_ACCUM_EN
    localparam logic [DATA_W-1:0] MAXV = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MINV = {1'b1, {(DATA_W-1){1'b0}}};

    logic sat_q;
    logic sat_d;
    logic [DATA_W:0] sum;

    always_comb begin
        mem_d = mem_q;
        vld_d = vld_q;
        sat_d = sat_q;
        sum   = '0;
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                vld_d[i] = 1'b1;
                if (vld_q[i]) begin
                    sum = {mem_q[i][DATA_W-1], mem_q[i]}
                        + {din[i][DATA_W-1], din[i]};
                    // Sign bits disagree only on overflow.
                    if (sum[DATA_W] != sum[DATA_W-1]) begin
                        mem_d[i] = sum[DATA_W] ? MINV : MAXV;
                        sat_d    = 1'b1;
                    end else begin
                        mem_d[i] = sum[DATA_W-1:0];
                    end
                end else begin
                    mem_d[i] = din[i];
                end
            end
        end
        if (bus.clr) begin
            for (int i = 0; i < 4; i++) mem_d[i] = '0;
            vld_d = '0;
            sat_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) sat_q <= 1'b0;
        else       sat_q <= sat_d;
    end

    assign bus.accum_sat = sat_q;
`else
    always_comb begin
        mem_d = mem_q;
        vld_d = vld_q;
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                vld_d[i] = 1'b1;
                mem_d[i] = din[i];
            end
        end
        if (bus.clr) begin
            for (int i = 0; i < 4; i++) mem_d[i] = '0;
            vld_d = '0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < 4; i++) mem_q[i] <= '0;
            vld_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) mem_q[i] <= mem_d[i];
            vld_q <= vld_d;
        end
    end

    // Reads sample mem_q, so a same-cycle write is seen only next time.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
        end else if (bus.clr) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            rd_hit_q   <= bus.rd_en & vld_q[bus.rd_addr];
            if (bus.rd_en) rd_data_q <= mem_q[bus.rd_addr];
        end
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_hit      = rd_hit_q;
    assign bus.entry_valid = vld_q;
    assign bus.full        = full;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            saddr_q <= '0;
            sdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            saddr_q <= saddr_d;
            sdata_q <= sdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        saddr_d = saddr_q;
        sdata_d = sdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.scan_start) begin
                    state_d = full ? S_SHOW : S_WAIT;
                    cnt_d   = '0;
                    saddr_d = '0;
                end
            end
            S_WAIT: begin
                if (full) begin
                    state_d = S_SHOW;
                    cnt_d   = '0;
                    saddr_d = '0;
                end
            end
            S_SHOW: begin
                sdata_d = mem_q[saddr_q];
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    // Wraps 3 -> 0 as the scan ends.
                    saddr_d = saddr_q + 2'd1;
                    if (saddr_q == 2'd3) state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                saddr_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.clr) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            saddr_d = '0;
            sdata_d = '0;
        end
    end

    always_comb begin
        bus.scan_busy = (state_q != S_IDLE);
        bus.scan_done = (state_q == S_DONE);
    end

    assign bus.scan_addr = saddr_q;
    assign bus.scan_data = sdata_q;

endmodule

// File: tb/tb_sys_result_buffer.sv
// Directed bench for sys_result_buffer (DATA_W=16, HOLD_CYCLES=4).
// Expected values depend on RESULT_ACCUM_EN where accumulation applies.
module tb_sys_result_buffer;

    localparam int DW = 16;

    logic clk;
    logic rstb;
    int   errors;
    int   checks;

    sys_result_buffer_if #(.DATA_W(DW)) bus ();

    sys_result_buffer #(
        .DATA_W      (DW),
        .HOLD_CYCLES (4)
    ) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.clr = 0;
        bus.we_c11 = 0; bus.we_c12 = 0;
        bus.we_c21 = 0; bus.we_c22 = 0;
        bus.din_c11 = '0; bus.din_c12 = '0;
        bus.din_c21 = '0; bus.din_c22 = '0;
        bus.rd_en = 0; bus.rd_addr = '0;
        bus.scan_start = 0;
    endtask

    task automatic do_clr();
        bus.clr = 1;
        step();
        bus.clr = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rstb = 0;
        #23;
        rstb = 1;
        step();
        checks++;
        if ({bus.rd_data, bus.rd_valid, bus.rd_hit} !== 18'd0) begin
            errors++;
            $display("FAIL reset_rd: got %h want 0",
                     {bus.rd_data, bus.rd_valid, bus.rd_hit});
        end
        checks++;
        if ({bus.entry_valid, bus.full, bus.scan_busy} !== 6'd0) begin
            errors++;
            $display("FAIL reset_status: got %b want 0",
                     {bus.entry_valid, bus.full, bus.scan_busy});
        end
        checks++;
        if ({bus.scan_addr, bus.scan_data, bus.scan_done} !== 19'd0) begin
            errors++;
            $display("FAIL reset_scan: got %h want 0",
                     {bus.scan_addr, bus.scan_data, bus.scan_done});
        end
        bus.rd_en = 1; bus.rd_addr = 2'd2;
        step();
        bus.rd_en = 0;
        checks++;
        if ({bus.rd_valid, bus.rd_hit, bus.rd_data} !== {1'b1, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL reset_read: got v=%b h=%b d=%0d want v=1 h=0 d=0",
                     bus.rd_valid, bus.rd_hit, bus.rd_data);
        end
    endtask

    task automatic test_writes();
        logic [DW-1:0] exp [4];
        exp[0] = 16'd5; exp[1] = 16'(-3);
        exp[2] = 16'd7; exp[3] = 16'd100;
        bus.we_c11 = 1; bus.din_c11 = exp[0];
        bus.we_c12 = 1; bus.din_c12 = exp[1];
        bus.we_c21 = 1; bus.din_c21 = exp[2];
        bus.we_c22 = 1; bus.din_c22 = exp[3];
        step();
        idle_inputs();
        checks++;
        if ({bus.entry_valid, bus.full} !== 5'b11111) begin
            errors++;
            $display("FAIL wr_valid: got %b/%b want 1111/1",
                     bus.entry_valid, bus.full);
        end
        for (int i = 0; i < 4; i++) begin
            bus.rd_en = 1;
            bus.rd_addr = 2'(i);
            step();
            checks++;
            if ({bus.rd_valid, bus.rd_hit, bus.rd_data} !== {2'b11, exp[i]}) begin
                errors++;
                $display("FAIL b2b_read%0d: got v=%b h=%b d=%0d want v=1 h=1 d=%0d",
                         i, bus.rd_valid, bus.rd_hit,
                         $signed(bus.rd_data), $signed(exp[i]));
            end
        end
        bus.rd_en = 0;
        step();
        checks++;
        if ({bus.rd_valid, bus.rd_hit, bus.rd_data} !== {2'b00, 16'd100}) begin
            errors++;
            $display("FAIL rd_idle_hold: got v=%b h=%b d=%0d want v=0 h=0 d=100",
                     bus.rd_valid, bus.rd_hit, bus.rd_data);
        end
    endtask

    task automatic test_rbw();
        logic [DW-1:0] second;
`ifdef RESULT_ACCUM_EN
        second = 16'd51;
`else
        second = 16'd42;
`endif
        do_clr();
        bus.we_c12 = 1; bus.din_c12 = 16'd9;
        step();
        bus.rd_en = 1; bus.rd_addr = 2'd1;
        bus.din_c12 = 16'd42;
        step();
        bus.we_c12 = 0;
        checks++;
        if (bus.rd_data !== 16'd9) begin
            errors++;
            $display("FAIL rbw_old: got %0d want 9", bus.rd_data);
        end
        step();
        bus.rd_en = 0;
        checks++;
        if (bus.rd_data !== second) begin
            errors++;
            $display("FAIL rbw_new: got %0d want %0d", bus.rd_data, second);
        end
    endtask

    task automatic test_scan();
        logic [DW-1:0] val [4];
        int dones;
        val[0] = 16'd11; val[1] = 16'd12;
        val[2] = 16'd21; val[3] = 16'd22;
        dones = 0;
        do_clr();
        bus.we_c11 = 1; bus.din_c11 = val[0];
        bus.we_c12 = 1; bus.din_c12 = val[1];
        bus.we_c21 = 1; bus.din_c21 = val[2];
        step();
        idle_inputs();
        bus.scan_start = 1;
        step();
        bus.scan_start = 0;
        step();
        checks++;
        if ({bus.scan_busy, bus.full, bus.scan_done} !== 3'b100) begin
            errors++;
            $display("FAIL scan_wait: got busy/full/done=%b want 100",
                     {bus.scan_busy, bus.full, bus.scan_done});
        end
        bus.we_c22 = 1; bus.din_c22 = val[3];
        step();
        bus.we_c22 = 0;
        step();
        for (int k = 0; k < 16; k++) begin
            checks++;
            if ({bus.scan_busy, bus.scan_done, bus.scan_addr} !== {2'b10, 2'(k / 4)}) begin
                errors++;
                $display("FAIL scan_step%0d: got busy=%b done=%b addr=%0d want 1 0 %0d",
                         k, bus.scan_busy, bus.scan_done, bus.scan_addr, k / 4);
            end
            if (k % 4 == 2) begin
                checks++;
                if (bus.scan_data !== val[k / 4]) begin
                    errors++;
                    $display("FAIL scan_data%0d: got %0d want %0d",
                             k / 4, bus.scan_data, val[k / 4]);
                end
            end
            bus.scan_start = (k == 5);
            step();
            dones += int'(bus.scan_done);
        end
        bus.scan_start = 0;
        checks++;
        if ({bus.scan_done, bus.scan_busy, bus.scan_addr, bus.scan_data}
            !== {2'b11, 2'd0, val[3]}) begin
            errors++;
            $display("FAIL scan_done: got done=%b busy=%b addr=%0d data=%0d want 1 1 0 22",
                     bus.scan_done, bus.scan_busy, bus.scan_addr, bus.scan_data);
        end
        step();
        checks++;
        if ({bus.scan_done, bus.scan_busy, bus.scan_data} !== {2'b00, val[3]}) begin
            errors++;
            $display("FAIL scan_end: got done=%b busy=%b data=%0d want 0 0 22",
                     bus.scan_done, bus.scan_busy, bus.scan_data);
        end
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL scan_done_count: got %0d want 1", dones);
        end
    endtask

    task automatic test_clr_scan();
        int dones;
        dones = 0;
        bus.scan_start = 1;
        step();
        bus.scan_start = 0;
        for (int k = 0; k < 8; k++) step();
        checks++;
        if ({bus.scan_busy, bus.scan_addr} !== 3'b110) begin
            errors++;
            $display("FAIL clr_pre: got busy=%b addr=%0d want 1 2",
                     bus.scan_busy, bus.scan_addr);
        end
        bus.clr = 1;
        bus.we_c11 = 1; bus.din_c11 = 16'd77;
        step();
        idle_inputs();
        checks++;
        if ({bus.scan_busy, bus.scan_done, bus.entry_valid, bus.full,
             bus.scan_addr, bus.scan_data} !== 25'd0) begin
            errors++;
            $display("FAIL clr_scan: got busy=%b done=%b ev=%b full=%b addr=%0d data=%0d want all 0",
                     bus.scan_busy, bus.scan_done, bus.entry_valid,
                     bus.full, bus.scan_addr, bus.scan_data);
        end
        bus.rd_en = 1; bus.rd_addr = 2'd0;
        step();
        bus.rd_en = 0;
        dones += int'(bus.scan_done);
        checks++;
        if ({bus.rd_valid, bus.rd_hit, bus.rd_data} !== {2'b10, 16'd0}) begin
            errors++;
            $display("FAIL clr_we_drop: got v=%b h=%b d=%0d want v=1 h=0 d=0",
                     bus.rd_valid, bus.rd_hit, bus.rd_data);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            dones += int'(bus.scan_done);
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL clr_no_done: got %0d pulses want 0", dones);
        end
    endtask

    task automatic test_accum();
        logic [DW-1:0] exp1;
`ifdef RESULT_ACCUM_EN
        exp1 = 16'd32767;
`else
        exp1 = 16'd5000;
`endif
        do_clr();
        bus.we_c11 = 1; bus.din_c11 = 16'd30000;
        step();
        bus.din_c11 = 16'd5000;
        step();
        bus.we_c11 = 0;
        bus.rd_en = 1; bus.rd_addr = 2'd0;
        step();
        bus.rd_en = 0;
        checks++;
        if (bus.rd_data !== exp1) begin
            errors++;
            $display("FAIL accum_sum: got %0d want %0d", bus.rd_data, exp1);
        end
`ifdef RESULT_ACCUM_EN
        checks++;
        if (bus.accum_sat !== 1'b1) begin
            errors++;
            $display("FAIL accum_sat_set: got %b want 1", bus.accum_sat);
        end
`endif
        do_clr();
        bus.we_c11 = 1; bus.din_c11 = 16'(-4);
        step();
        bus.we_c11 = 0;
        bus.rd_en = 1; bus.rd_addr = 2'd0;
        step();
        bus.rd_en = 0;
        checks++;
        if (bus.rd_data !== 16'hFFFC) begin
            errors++;
            $display("FAIL accum_first: got %0d want -4", $signed(bus.rd_data));
        end
`ifdef RESULT_ACCUM_EN
        checks++;
        if (bus.accum_sat !== 1'b0) begin
            errors++;
            $display("FAIL accum_sat_clr: got %b want 0", bus.accum_sat);
        end
`endif
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_writes();
        test_rbw();
        test_scan();
        test_clr_scan();
        test_accum();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sys_result_buffer.md
Name: sys_result_buffer

Overview:
- Receiving end of the controller's result-buffer interface. Captures the 2x2 output tile C11..C22 from the systolic arrays under the per-element write enables.
- Serves random reads at the controller's 2-bit read address.
- Provides a timed scan-out sequencer that steps the display path through all four entries.
- Sits between the systolic array outputs, the controller (write enables, read address, rst_total) and the display logic.

Parameters:
- DATA_W, 16, width of each result entry (two's complement).
- HOLD_CYCLES, 4, cycles each entry is held on the scan output (minimum 1).

Ports:
- clk  in  1  system clock
- rstb  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear (driven from rst_total)
- we_c11, we_c12, we_c21, we_c22  in  1 each  per-entry write enables
- din_c11, din_c12, din_c21, din_c22  in  DATA_W each  write data per entry
- rd_en  in  1  read request
- rd_addr  in  2  read address: 0=C11, 1=C12, 2=C21, 3=C22
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  one-cycle pulse, read data valid
- rd_hit  out  1  addressed entry had been written, qualified by rd_valid
- entry_valid  out  4  bit i set once entry i has been written since clear
- full  out  1  all four entries valid
- scan_start  in  1  start scan-out request
- scan_busy  out  1  scan FSM not IDLE
- scan_addr  out  2  entry currently shown
- scan_data  out  DATA_W  registered value of entry scan_addr
- scan_done  out  1  one-cycle pulse at end of scan

Behaviour:
- Reset (rstb low, asynchronous): all entries, entry_valid, rd_data, rd_valid, rd_hit, scan_addr, scan_data, scan_done and the hold counter go to 0; FSM goes to IDLE.
- clr (synchronous):
  - Same effect as reset on the next edge; aborts any scan to IDLE without a scan_done pulse.
  - Has priority over writes, reads and scan_start in the same cycle.
- Writes:
  - Any combination of the four enables may be asserted in one cycle; each enabled entry loads its din and sets its entry_valid bit.
  - Rewriting a valid entry overwrites it.
- full = AND of entry_valid (combinational from registers).
- Reads:
  - rd_en in cycle N gives rd_data, rd_hit and rd_valid=1 in cycle N+1.
  - rd_valid is 0 in cycles with no request; rd_data holds its last value.
  - Read-before-write: a read of an entry written in the same cycle returns the old value.
  - An unwritten entry reads 0 with rd_hit=0.
  - Back-to-back reads are supported at one per cycle.
- Scan FSM, states IDLE, WAIT_FULL, SHOW, DONE:
  - IDLE: scan_start with full=1 goes to SHOW, scan_addr=0, hold counter=0. scan_start with full=0 goes to WAIT_FULL.
  - WAIT_FULL: goes to SHOW (scan_addr=0) on the cycle after full is seen high.
  - SHOW: scan_data <= entry[scan_addr] every cycle, so a write during SHOW is visible one cycle later. The hold counter counts 0..HOLD_CYCLES-1. At terminal count it clears and scan_addr increments. At terminal count with scan_addr=3 the FSM goes to DONE.
  - DONE: scan_done=1 for exactly one cycle, then IDLE. scan_addr returns to 0; scan_data holds the last value.
  - scan_start is ignored outside IDLE.
  - scan_busy=1 in WAIT_FULL, SHOW and DONE.
  - A full scan from entering SHOW takes 4*HOLD_CYCLES cycles plus 1 DONE cycle.
- Reads and the scan operate independently and concurrently.

Optional Feature:
- Macro RESULT_ACCUM_EN.
- When defined:
  - A write to a valid entry stores entry+din, sign-extended to DATA_W+1 and saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1], so multi-tile partial sums accumulate.
  - A write to an invalid entry (first write after clear or reset) loads din.
  - Adds output accum_sat (1 bit), a sticky flag set when any saturation occurs; cleared by reset or clr.
- When not defined: overwrite-only; accum_sat does not exist.

Test Plan:
- Reset and idle: hold rstb low, release → all outputs 0, scan_busy=0, full=0; then rd_en with rd_addr=2 → next cycle rd_valid=1, rd_data=0, rd_hit=0.
- Simultaneous writes: we_c11..we_c22 in one cycle with din=5, -3, 7, 100 → entry_valid=4'b1111, full=1. Reads of addrs 0..3 back-to-back → rd_data 5, -3, 7, 100 on consecutive cycles, each with rd_hit=1.
- Read-before-write: entry1=9; same cycle rd_en with rd_addr=1 and we_c12 with din=42 → rd_data=9. Repeated read → 42.
- Scan with HOLD_CYCLES=4:
  - scan_start at full=0 → scan_busy=1 in WAIT_FULL.
  - Writing the last entry → SHOW; scan_addr shows 0,1,2,3 for 4 cycles each.
  - scan_done pulses once, 16 cycles after entering SHOW.
  - scan_start pulses mid-scan are ignored.
- clr mid-scan: clr during SHOW at scan_addr=2 → next cycle IDLE, entry_valid=0, scan_data=0, no scan_done pulse. Simultaneous we_c11 is discarded.
- RESULT_ACCUM_EN, DATA_W=16:
  - Write 30000 then 5000 to C11 → 32767, accum_sat=1.
  - clr then write -4 → -4, accum_sat=0.
  - Without the macro, the same sequence stores 5000.
